input_memory_wrapper: RTL and testbench

INPUT_MEMORY_WRAPPER -- requirements
Module: input_memory_wrapper

---
 rtl/input_memory_wrapper.sv | 71 +++++++
 tb/tb_input_memory_wrapper.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/input_memory_wrapper.sv
// input_memory_wrapper: twin write-anywhere memories streamed out element by element on request
module input_memory_wrapper #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int DEPTH        = VECTOR_WIDTH * DATA_WIDTH,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  start_reading,
    output logic                  reading_done,
    output logic [DATA_WIDTH-1:0] mem1_output,
    output logic [DATA_WIDTH-1:0] mem2_output,
    output logic                  data_valid,
    output logic [2:0]            element_count
);
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VECTOR_WIDTH - 1);
    state_t state, next_state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];
    logic [DATA_WIDTH-1:0] mem2 [DEPTH];
    // state register; rst_n is active-high despite its name
    always_ff @(posedge clk)
        state <= rst_n ? IDLE : next_state;
    // sequencing: start only honoured from IDLE, DONE lasts a single cycle
    always_comb
        next_state = (state == IDLE) ? (start_reading ? READ : IDLE) :
                     (state == READ) ? ((idx == LAST) ? DONE : READ) : IDLE;
    // storage: writes accepted in every state; reads below see pre-write contents
    always_ff @(posedge clk)
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem1[i] <= '0;
                mem2[i] <= '0;
            end
        end else if (write_en && 32'(write_addr) < DEPTH) begin
            mem1[write_addr] <= data_a;
            mem2[write_addr] <= data_b;
        end
    // read datapath and status flags; outputs hold when not streaming
    always_ff @(posedge clk)
        if (rst_n) begin
            idx           <= '0;
            reading_done  <= 1'b0;
            data_valid    <= 1'b0;
            element_count <= '0;
            mem1_output   <= '0;
            mem2_output   <= '0;
        end else if (state == IDLE) begin
            data_valid <= 1'b0;
            if (start_reading) begin
                idx           <= '0;
                reading_done  <= 1'b0;
                element_count <= '0;
            end
        end else if (state == READ) begin
            mem1_output   <= mem1[idx];
            mem2_output   <= mem2[idx];
            data_valid    <= 1'b1;
            element_count <= 3'(idx + ADDR_WIDTH'(1));
            idx           <= idx + ADDR_WIDTH'(1);
        end else begin
            data_valid   <= 1'b0;
            reading_done <= 1'b1;
        end
endmodule

// File: tb/tb_input_memory_wrapper.sv
// tb_input_memory_wrapper: directed vectors checked against a cycle-timeline model and literal beats
module tb_input_memory_wrapper;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_en = 1'b0;
    logic [4:0] write_addr = '0;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic       start_reading = 1'b0;
    logic       reading_done;
    logic [7:0] mem1_output;
    logic [7:0] mem2_output;
    logic       data_valid;
    logic [2:0] element_count;
    int errors = 0;
    int checks = 0;

    input_memory_wrapper dut (
        .clk(clk),
        .rst_n(rst),
        .write_en(write_en),
        .write_addr(write_addr),
        .data_a(data_a),
        .data_b(data_b),
        .start_reading(start_reading),
        .reading_done(reading_done),
        .mem1_output(mem1_output),
        .mem2_output(mem2_output),
        .data_valid(data_valid),
        .element_count(element_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: k counts edges since an accepted start (0 = not sequencing)
    logic [7:0] em1 [32];
    logic [7:0] em2 [32];
    int         k = 0;
    logic       e_done, e_valid, armed = 1'b0;
    logic [2:0] e_cnt;
    logic [7:0] e_o1, e_o2;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                em1[i] <= 8'h00;
                em2[i] <= 8'h00;
            end
            k <= 0;
            e_done <= 1'b0;
            e_valid <= 1'b0;
            e_cnt <= 3'd0;
            e_o1 <= 8'h00;
            e_o2 <= 8'h00;
            armed <= 1'b1;
        end else begin
            if (write_en && write_addr < 32) begin
                em1[write_addr] <= data_a;
                em2[write_addr] <= data_b;
            end
            if (k == 0) begin
                if (start_reading) begin
                    k <= 1;
                    e_done <= 1'b0;
                    e_cnt <= 3'd0;
                end
            end else if (k <= 4) begin
                e_o1 <= em1[k-1];
                e_o2 <= em2[k-1];
                e_valid <= 1'b1;
                e_cnt <= 3'(k);
                k <= k + 1;
            end else begin
                e_valid <= 1'b0;
                e_done <= 1'b1;
                k <= 0;
            end
        end
    end

    always @(negedge clk)
        if (armed) begin
            chk("model_reading_done", reading_done, e_done);
            chk("model_data_valid", data_valid, e_valid);
            chk("model_element_count", element_count, e_cnt);
            chk("model_mem1_output", mem1_output, e_o1);
            chk("model_mem2_output", mem2_output, e_o2);
        end

    task automatic wr(input logic [4:0] a, input logic [7:0] d1, input logic [7:0] d2);
        write_en = 1'b1;
        write_addr = a;
        data_a = d1;
        data_b = d2;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic wr4(input logic [31:0] va, input logic [31:0] vb);
        for (int i = 0; i < 4; i++) wr(5'(i), va[8*i +: 8], vb[8*i +: 8]);
    endtask

    // poke: 1 = start during READ, 2 = start sampled in DONE, 3 = write addr 2 while it is read
    task automatic do_read(input logic [31:0] ea, input logic [31:0] eb, input int poke);
        start_reading = 1'b1;
        @(negedge clk);
        start_reading = 1'b0;
        chk("start_clears_done", reading_done, 0);
        chk("start_clears_count", element_count, 0);
        chk("start_no_valid", data_valid, 0);
        for (int i = 0; i < 4; i++) begin
            if (poke == 1 && i == 1) start_reading = 1'b1;
            if (poke == 3 && i == 2) begin
                write_en = 1'b1;
                write_addr = 5'd2;
                data_a = 8'h55;
                data_b = 8'h66;
            end
            @(negedge clk);
            start_reading = 1'b0;
            write_en = 1'b0;
            chk("beat_valid", data_valid, 1);
            chk("beat_count", element_count, i + 1);
            chk("beat_mem1", mem1_output, ea[8*i +: 8]);
            chk("beat_mem2", mem2_output, eb[8*i +: 8]);
        end
        if (poke == 2) start_reading = 1'b1;
        @(negedge clk);
        start_reading = 1'b0;
        chk("done_flag", reading_done, 1);
        chk("done_valid_low", data_valid, 0);
        chk("done_count", element_count, 4);
        chk("done_hold_mem1", mem1_output, ea[31:24]);
        chk("done_hold_mem2", mem2_output, eb[31:24]);
        if (poke == 2) begin
            @(negedge clk);
            chk("done_start_ignored", data_valid, 0);
            chk("done_start_ignored_flag", reading_done, 1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_done", reading_done, 0);
        chk("reset_valid", data_valid, 0);
        chk("reset_count", element_count, 0);
        chk("reset_mem1", mem1_output, 0);
        chk("reset_mem2", mem2_output, 0);
        wr4(32'h04030201, 32'h08070605);
        do_read(32'h04030201, 32'h08070605, 0);
        wr(5'd0, 8'hAA, 8'hBB);
        wr(5'd1, 8'hCC, 8'hDD);
        wr(5'd0, 8'hEE, 8'hFF);
        do_read(32'h0403CCEE, 32'h0807DDFF, 0);
        do_read(32'h0403CCEE, 32'h0807DDFF, 3);
        do_read(32'h0455CCEE, 32'h0866DDFF, 0);
        wr4(32'h00000000, 32'h00000000);
        do_read(32'h00000000, 32'h00000000, 0);
        wr4(32'hFFFFFFFF, 32'hFFFFFFFF);
        do_read(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        repeat (2) @(negedge clk);
        chk("done_level_held", reading_done, 1);
        chk("count_held", element_count, 4);
        do_read(32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        wr4(32'h44332211, 32'h88776655);
        start_reading = 1'b1;
        @(negedge clk);
        start_reading = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_beat2", mem1_output, 8'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", data_valid, 0);
        chk("abort_done", reading_done, 0);
        chk("abort_count", element_count, 0);
        chk("abort_mem1", mem1_output, 0);
        chk("abort_mem2", mem2_output, 0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", data_valid, 0);
        chk("abort_no_done", reading_done, 0);
        do_read(32'h00000000, 32'h00000000, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
